vga_draw_arbiter: RTL

- Shares the single VGA adapter write port (xout/yout/colourOut/drawEn) between N drawing engines: rocket, alien grid, bullets, full-screen title/game-over painter.
- Each engine requests the port for a whole sprite/burst, owns it until release, then the next requester is granted in round-robin order.
- Sits between the per-object datapaths and the VGA adapter in the top level.

---
 rtl/vga_draw_arbiter_if.sv | 29 ++
 rtl/vga_draw_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/vga_draw_arbiter_if.sv
// Shared VGA write-port bundle between the drawing engines and vga_draw_arbiter.
// master = arbiter side (grants, VGA pixel port); slave = engine/requester side.
interface vga_draw_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [8*N-1:0] x_in;
  logic [7*N-1:0] y_in;
  logic [3*N-1:0] colour_in;
  logic [N-1:0]   plot_in;
  logic [N-1:0]   gnt;
  logic [7:0]     xout;
  logic [6:0]     yout;
  logic [2:0]     colourOut;
  logic           drawEn;
  logic           busy;
  logic [N-1:0]   timeout_flag;

  modport master (
    input  req, done, x_in, y_in, colour_in, plot_in,
    output gnt, xout, yout, colourOut, drawEn, busy, timeout_flag
  );

  modport slave (
    output req, done, x_in, y_in, colour_in, plot_in,
    input  gnt, xout, yout, colourOut, drawEn, busy, timeout_flag
  );
endinterface

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA write port; each engine keeps it for a whole burst.
// Optional DRAW_WATCHDOG_EN adds a per-grant hold limit (MAX_HOLD) with sticky timeout flags.
module vga_draw_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 20000
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_draw_arbiter_if.master    bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] winner;
  logic [N-1:0]  eligible;
  logic          any_req;
  logic          owner_release;
  logic          owner_timeout;

  logic [7:0] x_arr [N];
  logic [6:0] y_arr [N];
  logic [2:0] c_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign x_arr[i] = bus.x_in[8*i +: 8];
    assign y_arr[i] = bus.y_in[7*i +: 7];
    assign c_arr[i] = bus.colour_in[3*i +: 3];
  end

`ifdef DRAW_WATCHDOG_EN
  logic [14:0]  hold_cnt;
  logic [N-1:0] mask;
  logic [N-1:0] owner_onehot;

  assign owner_onehot  = N'(1) << owner;
  assign owner_timeout = (state == OWN) && !owner_release &&
                         (hold_cnt == 15'(MAX_HOLD - 1));
  assign eligible      = bus.req & ~mask;

  // A timed-out engine stays masked until it has dropped req for a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt         <= '0;
      mask             <= '0;
      bus.timeout_flag <= '0;
    end else begin
      hold_cnt         <= (state == OWN) ? hold_cnt + 15'd1 : '0;
      mask             <= (mask & bus.req) | (owner_timeout ? owner_onehot : '0);
      bus.timeout_flag <= bus.timeout_flag | (owner_timeout ? owner_onehot : '0);
    end
  end
`else
  assign owner_timeout    = 1'b0;
  assign eligible         = bus.req;
  assign bus.timeout_flag = '0;
`endif

  // First eligible requester at or after ptr, wrapping modulo N.
  always_comb begin : arbitrate
    int idx;
    winner  = ptr;
    any_req = |eligible;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (eligible[idx]) winner = IW'(idx);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    ptr_nxt       = ptr;
    owner_release = bus.done[owner] || !bus.req[owner];
    unique case (state)
      IDLE, RELEASE: begin
        if (any_req) begin
          state_nxt = OWN;
          owner_nxt = winner;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN: begin
        if (owner_release || owner_timeout) begin
          state_nxt = RELEASE;
          ptr_nxt   = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= '0;
      ptr           <= '0;
      bus.gnt       <= '0;
      bus.xout      <= '0;
      bus.yout      <= '0;
      bus.colourOut <= '0;
      bus.drawEn    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      bus.gnt  <= (state_nxt == OWN) ? (N'(1) << owner_nxt) : '0;
      bus.busy <= (state_nxt != IDLE);
      // The pixel presented alongside done is still forwarded; coordinates hold otherwise.
      if (state == OWN) begin
        bus.xout      <= x_arr[owner];
        bus.yout      <= y_arr[owner];
        bus.colourOut <= c_arr[owner];
        bus.drawEn    <= bus.plot_in[owner];
      end else begin
        bus.drawEn    <= 1'b0;
      end
    end
  end

endmodule
